// File: rtl/instr_pkg.sv
// Instruction-level encodings; the 3-bit field leaves room for codes the shifter
// does not implement.
package instr_pkg;

   typedef enum logic [2:0] {
      ROLL   = 3'd0,
      ROLR   = 3'd1,
      SHIFTL = 3'd2,
      SHIFTR = 3'd3
   } opcode_t;

endpackage

// File: rtl/types_pkg.sv
// Shared scalar types, the iterative-shifter FSM state and the operand width decode
// used by the shift and bitwise units.
package types_pkg;

   typedef logic [63:0] ulong_t;
   typedef logic [7:0]  ubyte_t;

   typedef enum logic [1:0] {
      BITS_8  = 2'd0,
      BITS_16 = 2'd1,
      BITS_32 = 2'd2,
      BITS_64 = 2'd3
   } sizeFlags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } shifter_state_t;

   typedef struct packed {
      logic [6:0] w;
      ulong_t     mask;
   } width_t;

   function automatic width_t decode_width(input sizeFlags_t s);
      width_t d;
      d = '0;
      case (s)
         BITS_8:  begin d.w = 7'd8;  d.mask = 64'h0000_0000_0000_00FF; end
         BITS_16: begin d.w = 7'd16; d.mask = 64'h0000_0000_0000_FFFF; end
         BITS_32: begin d.w = 7'd32; d.mask = 64'h0000_0000_FFFF_FFFF; end
         BITS_64: begin d.w = 7'd64; d.mask = 64'hFFFF_FFFF_FFFF_FFFF; end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/iter_shifter.sv
// Iterative shifter/rotator: one bit per cycle over a W-bit working register,
// optionally threading a carry bit through shifts and rotates.
module iter_shifter
   import types_pkg::*;
   import instr_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  opcode_t    op,
   input  sizeFlags_t size,
   input  logic       use_carry,
   input  logic       carry_in,
   input  ulong_t     a,
   input  ubyte_t     amount,
   output logic       resp_valid,
   input  logic       resp_ready,
   output ulong_t     result,
   output logic       carry_out,
   output logic       busy
);

   shifter_state_t state, state_nxt;
   ulong_t         r, r_step, r_fin, top;
   logic           c, c_step, c_fin, fill, msb;
   logic [7:0]     n, eff, wp1, wm1;
   opcode_t        op_q;
   sizeFlags_t     size_q;
   logic           uc_q, accept, op_ok;
   width_t         acc, wq;

   assign acc    = decode_width(size);
   assign wq     = decode_width(size_q);
   assign top    = 64'd1 << (wq.w - 7'd1);
   assign msb    = |(r & top);
   assign wp1    = {1'b0, acc.w} + 8'd1;
   assign wm1    = {1'b0, acc.w} - 8'd1;
   assign accept = req_valid && (state == IDLE);
   assign op_ok  = op_q inside {ROLL, ROLR, SHIFTL, SHIFTR};

   // Step count decided at accept; unknown opcodes take zero steps.
   always_comb begin
      eff = '0;
      case (op)
         SHIFTL, SHIFTR: eff = (amount > wp1) ? wp1 : amount;
         ROLL, ROLR: begin
            if (use_carry) begin
               case (size)
                  BITS_8:  eff = amount % 8'd9;
                  BITS_16: eff = amount % 8'd17;
                  BITS_32: eff = amount % 8'd33;
                  default: eff = amount % 8'd65;
               endcase
            end else begin
               eff = amount & wm1;
            end
         end
         default: eff = '0;
      endcase
   end

   always_comb begin
      r_step = r;
      c_step = c;
      case (op_q)
         SHIFTR: begin c_step = r[0]; r_step = (r >> 1) | (fill ? top : '0); end
         SHIFTL: begin c_step = msb;  r_step = ((r << 1) | {63'd0, fill}) & wq.mask; end
         ROLR: begin
            c_step = r[0];
            r_step = (r >> 1) | ((uc_q ? c : r[0]) ? top : '0);
         end
         ROLL: begin
            c_step = msb;
            r_step = ((r << 1) | {63'd0, (uc_q ? c : msb)}) & wq.mask;
         end
         default: ;
      endcase
      r_fin = (n != 8'd0) ? r_step : r;
      c_fin = (n != 8'd0) ? c_step : c;
   end

   // A zero-count request still spends one STEP cycle, so latency is always 1+max(n,1).
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_nxt = STEP;
         end
         STEP: if (n <= 8'd1) state_nxt = DONE;
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r         <= '0;
         c         <= 1'b0;
         fill      <= 1'b0;
         n         <= '0;
         op_q      <= ROLL;
         size_q    <= BITS_8;
         uc_q      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
      end else if (accept) begin
         r      <= a & acc.mask;
         c      <= use_carry && carry_in;
         fill   <= use_carry && carry_in;
         op_q   <= op;
         size_q <= size;
         uc_q   <= use_carry;
         n      <= eff;
      end else if (state == STEP) begin
         if (n != 8'd0) begin
            r    <= r_step;
            c    <= c_step;
            fill <= 1'b0;
            n    <= n - 8'd1;
         end
         if (n <= 8'd1) begin
            result    <= op_ok ? r_fin : '0;
            carry_out <= op_ok && c_fin;
         end
      end
   end

endmodule
